// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand helpers for the RV32M
// multiply/divide unit. The ALU control decoder also imports the funct3 codes.
package muldiv_pkg;

  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

  // A is treated as signed by everything except the fully unsigned forms.
  function automatic logic md_a_signed(input logic [2:0] op);
    return !((op == MD_MULHU) || (op == MD_DIVU) || (op == MD_REMU));
  endfunction

  // B is signed only for the fully signed forms (MULHSU treats B unsigned).
  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // Unsigned magnitude; 0x80000000 maps to itself.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps on a shared 64-bit
// shift register and 33-bit adder/subtractor, then a sign/special-case fix-up.
module muldiv
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      operation,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] O
);

  md_state_e   state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, mag_b_q, o_q;
  logic        sign_a_q, sign_b_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic        busy_q, busy_d, done_q, done_d;

  logic        accept_s, last_s, sa_in_s, sb_in_s, b_zero_s;
  logic [32:0] add_a_s, add_b_s, sum_s;
  logic [63:0] step_s, prod_s;
  logic [31:0] fix_s;

  assign accept_s = (state_q == S_IDLE) && start && !flush;
  assign last_s   = (cnt_q == 5'(MD_ITER - 1));
  assign sa_in_s  = A[31] & md_a_signed(operation);
  assign sb_in_s  = B[31] & md_b_signed(operation);
  assign b_zero_s = (b_q == 32'd0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = start ? S_CALC : S_IDLE;
        S_CALC:  state_d = last_s ? S_FIX : S_CALC;
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output next values: busy tracks the next state, done follows the DONE state
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE) && !flush;
  end

  // Shared adder: add multiplicand for multiply, trial-subtract divisor for divide
  always_comb begin
    if (op_q[2]) begin
      add_a_s = acc_q[63:31];
      add_b_s = {1'b0, mag_b_q};
      sum_s   = add_a_s - add_b_s;
      if (sum_s[32]) step_s = {acc_q[62:0], 1'b0};
      else           step_s = {sum_s[31:0], acc_q[30:0], 1'b1};
    end else begin
      add_a_s = {1'b0, acc_q[63:32]};
      add_b_s = acc_q[0] ? {1'b0, mag_b_q} : 33'd0;
      sum_s   = add_a_s + add_b_s;
      step_s  = {sum_s, acc_q[31:1]};
    end
  end

  // Result selection with sign fix-up and divide-by-zero handling
  always_comb begin
    prod_s = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;
    case (op_q)
      MD_MUL:                       fix_s = prod_s[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_s = prod_s[63:32];
      MD_DIV, MD_DIVU: begin
        if (b_zero_s)                 fix_s = 32'hFFFF_FFFF;
        else if (sign_a_q ^ sign_b_q) fix_s = 32'd0 - acc_q[31:0];
        else                          fix_s = acc_q[31:0];
      end
      MD_REM, MD_REMU: begin
        if (b_zero_s)      fix_s = a_q;
        else if (sign_a_q) fix_s = 32'd0 - acc_q[63:32];
        else               fix_s = acc_q[63:32];
      end
      default:             fix_s = 32'd0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mag_b_q  <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      o_q      <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept_s) begin
        op_q     <= operation;
        a_q      <= A;
        b_q      <= B;
        sign_a_q <= sa_in_s;
        sign_b_q <= sb_in_s;
        mag_b_q  <= md_mag(B, sb_in_s);
        acc_q    <= {32'd0, md_mag(A, sa_in_s)};
        cnt_q    <= 5'd0;
      end else if ((state_q == S_CALC) && !flush) begin
        acc_q <= step_s;
        cnt_q <= cnt_q + 5'd1;
      end else if ((state_q == S_FIX) && !flush) begin
        o_q <= fix_s;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign O    = o_q;

endmodule

// File: doc/muldiv.md
# muldiv

Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU, covering the operations the ALU does not. It takes the same A/B operands and a 3-bit `operation` code (the RV32M funct3). It computes the result over a fixed number of cycles with a start/busy/done handshake, and holds the result until the next accepted request. The pipeline stalls on `busy` and writes back `O` on `done`.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `flush`  in  1  synchronous abort of an in-flight operation.
- `operation`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`, `B`  in  32  operands (rs1, rs2); sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `O` is valid from this cycle on.
- `O`  out  32  result register.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + `start` → latch `operation`, A and B into internal registers; load the magnitude/sign registers; counter = 0; go to CALC.
- CALC: one radix-2 step per cycle for 32 cycles, then go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring divide on unsigned magnitudes; 32-bit remainder plus 1 guard bit.
- FIX: apply the result sign and the special cases, write `O`, go to DONE.
- DONE: pulse `done`, go to IDLE.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - Magnitudes are taken as unsigned 32-bit values, so |0x80000000| = 0x80000000.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - Product sign = sign(A) ^ sign(B); the full 64-bit value is negated when the sign is set.
  - Quotient sign = sign(A) ^ sign(B); remainder takes the sign of A.
- Divide by zero (B = 0): DIV/DIVU → 0xFFFFFFFF; REM/REMU → A unchanged. The sign fix is not applied.
- Signed overflow (DIV/REM with A = 0x80000000, B = 0xFFFFFFFF): DIV → 0x80000000, REM → 0. This falls out of the magnitude datapath; no override is needed.
- Latency is fixed for every operation, including the special cases; there is no early termination.
- `start` while not in IDLE is ignored; the request is not queued.
- `flush` in any state → IDLE next cycle. `busy` and `done` go low; `O` keeps its prior value.
- `flush` and `start` together in IDLE: `flush` wins and nothing is accepted.

## Timing
- Reset values: `busy` = 0, `done` = 0, `O` = 0, state = IDLE, all internal registers = 0.
- `rst` asserted mid-operation clears everything immediately (asynchronously).
- `start` sampled at edge E0:
  - `busy` rises after E0 and falls after E34.
  - CALC occupies E1–E32; FIX is E33; `O` is updated at E33.
  - `done` is high exactly one cycle, between E34 and E35 (state DONE).
- Back-to-back operation: `start` asserted in the cycle after `done` is accepted, so the issue interval is 35 cycles.
- `O` is stable from `done` until the FIX of the next accepted operation.
- Operand or `operation` changes after E0 have no effect.

## Structure
- `muldiv_pkg` holds:
  - the state enum;
  - funct3 constants `MD_MUL` … `MD_REMU`;
  - `XLEN`;
  - the iteration-count constant (32).
- The ALU control decoder imports the funct3 constants from `muldiv_pkg`.
- Single module, no sub-module. Multiply and divide share the 64-bit shift register and the 33-bit add/sub.

## Test plan
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → O = 0xFFFFFFFE; MUL on the same operands → 0x00000001. `done` pulses exactly once, 35 cycles after `start`, and `busy` is high for 34 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU A = 0xFFFFFFFF, B = 0xFFFFFFFF → 0xFFFFFFFF; MUL 0xFFFFFFF9 × 3 → 0xFFFFFFEB.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM on the same → 0xFFFFFFFF; DIVU 7 / 2 → 3; REMU 7 / 2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF; DIV 0xFFFFFFFB / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same → 0.
- Second `start` with new operands at cycle 10 of a MUL is ignored; the first result is produced at nominal timing. `flush` at cycle 20 → `busy` = 0 next cycle, no `done`, `O` unchanged. `flush` and `start` together in IDLE → no operation accepted.
- `rst` pulsed mid-CALC → `busy`, `done` and `O` are 0 immediately. A subsequent DIVU 100 / 7 → 14 with normal latency.
